// File: rtl/fetch_pkg.sv
// fetch_pkg: shared entry type, state encoding and constants for the fetch queue
package fetch_pkg;
   localparam int INST_BYTES = 4;
   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] inst;
   } fetch_entry_t;
   typedef enum logic [1:0] {RUN, STALL, FLUSH} fetch_state_t;
endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: in-order queue with flush; pointers carry an extra wrap bit
module fetch_fifo import fetch_pkg::*; #(
   parameter int  DEPTH = 4,
   parameter type T     = fetch_entry_t
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   push,
   input  T                       push_data,
   input  logic                   pop,
   input  logic                   flush,
   output logic                   full,
   output logic                   empty,
   output logic [$clog2(DEPTH):0] count,
   output T                       head
);
   localparam int AW = $clog2(DEPTH);
   logic [AW:0] wr_ptr, rd_ptr;
   T mem [DEPTH];
   assign count = wr_ptr - rd_ptr;
   assign empty = wr_ptr == rd_ptr;
   assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   // head reads only stored state, so a push is never visible in the same cycle
   assign head  = empty ? '0 : mem[rd_ptr[AW-1:0]];
   always_ff @(posedge clk) begin
      if (rst || flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (push && !full) wr_ptr <= wr_ptr + (AW+1)'(1);
         if (pop && !empty) rd_ptr <= rd_ptr + (AW+1)'(1);
      end
   end
   always_ff @(posedge clk)
      if (push && !full) mem[wr_ptr[AW-1:0]] <= push_data;
endmodule

// File: rtl/inst_fetch_queue.sv
// inst_fetch_queue: credit-limited sequential fetch with redirect flush and stale-response drop
module inst_fetch_queue import fetch_pkg::*; #(
   parameter int          DEPTH       = 4,
   parameter int          MEM_LATENCY = 2,
   parameter logic [31:0] RESET_PC    = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst_b,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_valid,
   input  logic [31:0] imem_data,
   input  logic        redirect_en,
   input  logic [31:0] redirect_pc,
   input  logic        halted,
   output logic        inst_valid,
   output logic [31:0] inst,
   output logic [31:0] inst_pc,
   input  logic        inst_ready
);
   localparam int CW = $clog2(DEPTH) + 1;
   logic [31:0] fetch_pc;
   logic [31:0] tag_pc [MEM_LATENCY];
   logic [MEM_LATENCY-1:0] tag_vld;
   logic [CW-1:0] count, inflight, drop_cnt;
   logic resp, push, full, empty, credit;
   fetch_entry_t head, resp_entry;
   fetch_state_t state, state_nxt;
   // responses to requests issued before the last reset carry no valid tag and are ignored
   assign resp       = imem_valid && tag_vld[MEM_LATENCY-1];
   assign push       = resp && drop_cnt == '0 && !full;
   assign credit     = ({1'b0, count} + {1'b0, inflight}) < (CW+1)'(DEPTH);
   assign resp_entry = '{pc: tag_pc[MEM_LATENCY-1], inst: imem_data};
   fetch_fifo #(.DEPTH(DEPTH), .T(fetch_entry_t)) u_fifo (
      .clk       (clk),
      .rst       (rst_b),
      .push      (push),
      .push_data (resp_entry),
      .pop       (inst_valid && inst_ready),
      .flush     (redirect_en),
      .full      (full),
      .empty     (empty),
      .count     (count),
      .head      (head)
   );
   always_ff @(posedge clk)
      state <= rst_b ? RUN : state_nxt;
   always_comb
      state_nxt = redirect_en      ? FLUSH :
                  (state == FLUSH) ? RUN :
                  (state == RUN)   ? ((!credit || halted) ? STALL : RUN) :
                  (credit && !halted) ? RUN : STALL;
   always_comb begin
      imem_req   = !rst_b && !halted && !redirect_en && credit;
      imem_addr  = fetch_pc;
      inst_valid = !empty;
      inst       = head.inst;
      inst_pc    = head.pc;
   end
   always_ff @(posedge clk) begin
      if (rst_b) begin
         fetch_pc <= RESET_PC;
         inflight <= '0;
         drop_cnt <= '0;
         tag_vld  <= '0;
      end else begin
         for (int i = MEM_LATENCY - 1; i > 0; i--) tag_vld[i] <= tag_vld[i-1];
         tag_vld[0] <= imem_req;
         inflight   <= inflight + CW'(imem_req) - CW'(resp);
         fetch_pc   <= redirect_en ? {redirect_pc[31:2], 2'b00} :
                       imem_req    ? fetch_pc + 32'(INST_BYTES) : fetch_pc;
         // everything still outstanding at a redirect belongs to the old path
         drop_cnt   <= redirect_en ? inflight - CW'(resp) :
                       drop_cnt - CW'(resp && drop_cnt != '0);
      end
   end
   always_ff @(posedge clk) begin
      tag_pc[0] <= fetch_pc;
      for (int i = 1; i < MEM_LATENCY; i++) tag_pc[i] <= tag_pc[i-1];
   end
endmodule

// File: tb/tb_inst_fetch_queue.sv
// tb_inst_fetch_queue: fixed-latency memory model plus in-order scoreboard for the fetch queue
module tb_inst_fetch_queue;
   import fetch_pkg::*;
   localparam int DEPTH = 4;
   localparam int MEM_LATENCY = 2;
   localparam logic [31:0] RESET_PC = 32'h0000_0000;
   logic clk = 0, rst_b = 1, imem_valid = 0, redirect_en = 0, halted = 0, inst_ready = 0;
   logic imem_req, inst_valid;
   logic [31:0] imem_data = 0, redirect_pc = 0;
   logic [31:0] imem_addr, inst, inst_pc;
   int n_chk = 0, n_fail = 0, cyc = 0;
   logic due_v [16] = '{default: 1'b0};
   logic due_live [16] = '{default: 1'b0};
   logic [31:0] due_a [16] = '{default: 32'h0};
   logic [31:0] due_mpc [16] = '{default: 32'h0};
   logic [31:0] m_pc = RESET_PC;
   fetch_entry_t exp_q [$];
   always #5 clk = ~clk;
   inst_fetch_queue #(.DEPTH(DEPTH), .MEM_LATENCY(MEM_LATENCY), .RESET_PC(RESET_PC)) dut (
      .clk         (clk),
      .rst_b       (rst_b),
      .imem_req    (imem_req),
      .imem_addr   (imem_addr),
      .imem_valid  (imem_valid),
      .imem_data   (imem_data),
      .redirect_en (redirect_en),
      .redirect_pc (redirect_pc),
      .halted      (halted),
      .inst_valid  (inst_valid),
      .inst        (inst),
      .inst_pc     (inst_pc),
      .inst_ready  (inst_ready)
   );
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
      n_chk++;
      if (got !== want) begin
         n_fail++;
         $display("FAIL %s got=%h want=%h", tag, got, want);
      end
   endtask
   task automatic next_hs(output logic [31:0] pc);
      int n = 0;
      pc = '0;
      while (!(inst_valid && inst_ready) && n < 20) begin
         @(negedge clk);
         #3;
         n++;
      end
      if (n >= 20) check("hs_timeout", n, 0);
      else pc = inst_pc;
      @(negedge clk);
      #3;
   endtask
   // memory model drives responses; scoreboard tracks every request the bench expects to surface
   always @(negedge clk) begin
      int idx;
      logic live;
      logic [31:0] mpc;
      fetch_entry_t e;
      cyc++;
      idx = cyc % 16;
      imem_valid = due_v[idx];
      imem_data = due_a[idx] ^ 32'hA5A5_0000;
      live = due_live[idx];
      mpc = due_mpc[idx];
      due_v[idx] = 1'b0;
      due_live[idx] = 1'b0;
      #2;
      if (rst_b) begin
         exp_q.delete();
         for (int i = 0; i < 16; i++) due_live[i] = 1'b0;
         m_pc = RESET_PC;
      end else begin
         check("head_valid", inst_valid, exp_q.size() != 0);
         if (inst_valid && inst_ready && !redirect_en && exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check("head_pc", inst_pc, e.pc);
            check("head_inst", inst, e.inst);
         end
         if (redirect_en || halted) check("req_blocked", imem_req, 0);
         if (imem_valid && live && !redirect_en) exp_q.push_back('{pc: mpc, inst: mpc ^ 32'hA5A5_0000});
         if (redirect_en) begin
            exp_q.delete();
            for (int i = 0; i < 16; i++) due_live[i] = 1'b0;
            m_pc = {redirect_pc[31:2], 2'b00};
         end
         if (imem_req) begin
            check("req_addr", imem_addr, m_pc);
            idx = (cyc + MEM_LATENCY) % 16;
            due_v[idx] = 1'b1;
            due_live[idx] = 1'b1;
            due_a[idx] = imem_addr;
            due_mpc[idx] = m_pc;
            m_pc += 32'd4;
         end
      end
   end
   initial begin
      logic [31:0] pc;
      int lat, n;
      repeat (3) @(negedge clk);
      #3;
      check("rst_valid", inst_valid, 0);
      check("rst_inst", inst, 0);
      check("rst_pc", inst_pc, 0);
      check("rst_req", imem_req, 0);
      @(negedge clk);
      rst_b = 0;
      inst_ready = 1;
      lat = -1;
      for (int k = 0; k < 10; k++) begin
         #3;
         if (inst_valid && lat < 0) lat = k;
         @(negedge clk);
      end
      check("first_lat", lat, MEM_LATENCY + 1);
      repeat (10) @(negedge clk);
      inst_ready = 0;
      n = 0;
      for (int k = 0; k < 12; k++) begin
         #3;
         if (k >= 6 && imem_req) n++;
         @(negedge clk);
      end
      #3;
      check("full_valid", inst_valid, 1);
      check("full_req", imem_req, 0);
      check("late_reqs", n, 0);
      check("queue_fill", exp_q.size(), DEPTH);
      @(negedge clk);
      inst_ready = 1;
      n = 0;
      for (int k = 0; k < 8; k++) begin
         #3;
         if (inst_valid) n++;
         @(negedge clk);
      end
      check("stream_valid", n, 8);
      redirect_en = 1;
      redirect_pc = 32'h0000_0103;
      @(negedge clk);
      redirect_en = 0;
      #3;
      check("flush_empty", inst_valid, 0);
      next_hs(pc);
      check("redir_pc0", pc, 32'h0000_0100);
      next_hs(pc);
      check("redir_pc1", pc, 32'h0000_0104);
      @(negedge clk);
      redirect_en = 1;
      redirect_pc = 32'h0000_0200;
      @(negedge clk);
      redirect_pc = 32'h0000_0300;
      @(negedge clk);
      redirect_en = 0;
      #3;
      next_hs(pc);
      check("b2b_pc", pc, 32'h0000_0300);
      @(negedge clk);
      redirect_en = 1;
      redirect_pc = 32'hFFFF_FFF8;
      @(negedge clk);
      redirect_en = 0;
      #3;
      next_hs(pc);
      check("wrap_pc0", pc, 32'hFFFF_FFF8);
      next_hs(pc);
      check("wrap_pc1", pc, 32'hFFFF_FFFC);
      next_hs(pc);
      check("wrap_pc2", pc, 32'h0000_0000);
      @(negedge clk);
      halted = 1;
      n = 0;
      for (int k = 0; k < 10; k++) begin
         #3;
         if (imem_req) n++;
         @(negedge clk);
      end
      #3;
      check("halt_reqs", n, 0);
      check("halt_drained", inst_valid, 0);
      @(negedge clk);
      halted = 0;
      for (int k = 0; k < 80; k++) begin
         @(negedge clk);
         inst_ready = 1'($urandom_range(0, 1));
         redirect_en = ($urandom_range(0, 11) == 0);
         redirect_pc = $urandom;
         halted = ($urandom_range(0, 9) == 0);
      end
      @(negedge clk);
      inst_ready = 1;
      redirect_en = 0;
      halted = 0;
      repeat (6) @(negedge clk);
      rst_b = 1;
      @(negedge clk);
      rst_b = 0;
      #3;
      check("mid_rst_valid", inst_valid, 0);
      check("mid_rst_inst", inst, 0);
      check("mid_rst_pc", inst_pc, 0);
      check("mid_rst_req", imem_req, 1);
      check("mid_rst_addr", imem_addr, RESET_PC);
      repeat (10) @(negedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
      $finish;
   end
endmodule
